// File: rtl/uart_pixel_collector.sv
// Frame collector behind the UART receiver: waits for a sync byte, streams IMG_W*IMG_H
// pixels into a frame buffer, then verifies a trailing XOR checksum with an idle-timeout abort.
module uart_pixel_collector #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    IMG_W       = 64,
    parameter int                    IMG_H       = 64,
    parameter int                    ADDR_WIDTH  = 12,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE   = 8'hA5,
    parameter int                    TO_WIDTH    = 24,
    parameter int                    TIMEOUT_CYC = 1000000
) (
    input  logic                  clk_i_pix,
    input  logic                  rsnt_i_pix,
    input  logic [DATA_WIDTH-1:0] data_i_pix,
    input  logic                  valid_i_pix,
    output logic                  mem_we_o_pix,
    output logic [ADDR_WIDTH-1:0] mem_addr_o_pix,
    output logic [DATA_WIDTH-1:0] mem_data_o_pix,
    output logic                  busy_o_pix,
    output logic                  frame_done_o_pix,
    output logic                  frame_err_o_pix,
    output logic [1:0]            err_code_o_pix
);

    localparam int                    N_PIX    = IMG_W * IMG_H;
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(N_PIX - 1);
    localparam logic [ADDR_WIDTH-1:0] PIX_ONE  = ADDR_WIDTH'(1);
    localparam logic [TO_WIDTH-1:0]   TO_LAST  = TO_WIDTH'(TIMEOUT_CYC - 1);
    localparam logic [TO_WIDTH-1:0]   TO_ONE   = TO_WIDTH'(1);
    localparam logic [1:0]            ERR_NONE = 2'b00;
    localparam logic [1:0]            ERR_CSUM = 2'b01;
    localparam logic [1:0]            ERR_TOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PIXELS = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] csum_step(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] b
    );
        return acc ^ b;
    endfunction

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] pix_cnt_r, pix_cnt_s;
    logic [DATA_WIDTH-1:0] csum_r, csum_s;
    logic [TO_WIDTH-1:0]   to_cnt_r, to_cnt_s;
    logic                  we_r, we_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  err_r, err_s;
    logic [1:0]            code_r, code_s;
    logic                  expire_s;

    // Next-state and next-output logic; a strobe always takes priority over timeout expiry.
    always_comb begin
        state_s   = state_r;
        pix_cnt_s = pix_cnt_r;
        csum_s    = csum_r;
        to_cnt_s  = to_cnt_r;
        we_s      = 1'b0;
        addr_s    = addr_r;
        data_s    = data_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        code_s    = code_r;
        expire_s  = (to_cnt_r == TO_LAST);

        case (state_r)
            ST_IDLE: begin
                to_cnt_s = {TO_WIDTH{1'b0}};
                if (valid_i_pix && (data_i_pix == SYNC_BYTE)) begin
                    state_s   = ST_PIXELS;
                    pix_cnt_s = {ADDR_WIDTH{1'b0}};
                    csum_s    = {DATA_WIDTH{1'b0}};
                    code_s    = ERR_NONE;
                    busy_s    = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_PIXELS: begin
                if (valid_i_pix) begin
                    we_s     = 1'b1;
                    addr_s   = pix_cnt_r;
                    data_s   = data_i_pix;
                    csum_s   = csum_step(csum_r, data_i_pix);
                    to_cnt_s = {TO_WIDTH{1'b0}};
                    if (pix_cnt_r == LAST_PIX) begin
                        state_s = ST_CHECK;
                    end else begin
                        pix_cnt_s = pix_cnt_r + PIX_ONE;
                    end
                end else if (expire_s) begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                    err_s    = 1'b1;
                    code_s   = ERR_TOUT;
                    to_cnt_s = {TO_WIDTH{1'b0}};
                end else begin
                    to_cnt_s = to_cnt_r + TO_ONE;
                end
            end
            ST_CHECK: begin
                if (valid_i_pix) begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                    to_cnt_s = {TO_WIDTH{1'b0}};
                    if (data_i_pix == csum_r) begin
                        done_s = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                        code_s = ERR_CSUM;
                    end
                end else if (expire_s) begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                    err_s    = 1'b1;
                    code_s   = ERR_TOUT;
                    to_cnt_s = {TO_WIDTH{1'b0}};
                end else begin
                    to_cnt_s = to_cnt_r + TO_ONE;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                busy_s   = 1'b0;
                to_cnt_s = {TO_WIDTH{1'b0}};
            end
        endcase
    end

    // State and output registers; reset discards any partial frame silently.
    always_ff @(posedge clk_i_pix or negedge rsnt_i_pix) begin
        if (!rsnt_i_pix) begin
            state_r   <= ST_IDLE;
            pix_cnt_r <= {ADDR_WIDTH{1'b0}};
            csum_r    <= {DATA_WIDTH{1'b0}};
            to_cnt_r  <= {TO_WIDTH{1'b0}};
            we_r      <= 1'b0;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            data_r    <= {DATA_WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            code_r    <= ERR_NONE;
        end else begin
            state_r   <= state_s;
            pix_cnt_r <= pix_cnt_s;
            csum_r    <= csum_s;
            to_cnt_r  <= to_cnt_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            data_r    <= data_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
            code_r    <= code_s;
        end
    end

    assign mem_we_o_pix     = we_r;
    assign mem_addr_o_pix   = addr_r;
    assign mem_data_o_pix   = data_r;
    assign busy_o_pix       = busy_r;
    assign frame_done_o_pix = done_r;
    assign frame_err_o_pix  = err_r;
    assign err_code_o_pix   = code_r;

endmodule

// File: tb/tb_uart_pixel_collector.sv
// Bench for uart_pixel_collector on a 4x4 image with a 100-cycle timeout: table rows,
// hand-timed corner sequences and random frames against a stream-parsing model.
module tb_uart_pixel_collector;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rsnt;
    logic [7:0] data;
    logic       valid;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       busy;
    logic       done;
    logic       ferr;
    logic [1:0] code;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_pixel_collector #(
        .DATA_WIDTH (8),
        .IMG_W      (4),
        .IMG_H      (4),
        .ADDR_WIDTH (4),
        .SYNC_BYTE  (8'hA5),
        .TO_WIDTH   (24),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk_i_pix       (clk),
        .rsnt_i_pix      (rsnt),
        .data_i_pix      (data),
        .valid_i_pix     (valid),
        .mem_we_o_pix    (mem_we),
        .mem_addr_o_pix  (mem_addr),
        .mem_data_o_pix  (mem_data),
        .busy_o_pix      (busy),
        .frame_done_o_pix(done),
        .frame_err_o_pix (ferr),
        .err_code_o_pix  (code)
    );

    // Write/pulse monitor, sampled just after each rising edge.
    logic [11:0] got_q[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    always @(posedge clk) begin
        #1;
        if (mem_we) got_q.push_back({mem_addr, mem_data});
        if (done) done_cnt++;
        if (ferr) err_cnt++;
    end

    typedef struct {
        int         njunk;
        logic [7:0] j0;
        logic [7:0] j1;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] delta;
        logic       exp_done;
        logic       exp_err;
        logic [1:0] exp_code;
    } vec_t;

    vec_t        tbl[6];
    logic [7:0]  stim_q[$];
    logic [11:0] exp_wr[$];
    logic        m_done;
    logic [1:0]  m_code;
    int          act_done;
    int          act_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        valid = v;
        data  = d;
    endtask

    task automatic build_frame(input int njunk, input logic [7:0] j0, input logic [7:0] j1,
                               input logic [7:0] base, input logic [7:0] step,
                               input logic [7:0] delta);
        logic [7:0] x;
        logic [7:0] p;
        stim_q.delete();
        if (njunk > 0) stim_q.push_back(j0);
        if (njunk > 1) stim_q.push_back(j1);
        stim_q.push_back(8'hA5);
        x = 8'h00;
        for (int i = 0; i < N; i++) begin
            p = 8'(base + step * 8'(i));
            stim_q.push_back(p);
            x = x ^ p;
        end
        stim_q.push_back(x ^ delta);
    endtask

    // Reference: parse the byte stream as the spec describes a frame.
    task automatic model_run();
        int         s;
        logic [7:0] x;
        exp_wr.delete();
        s = -1;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (s < 0 && stim_q[i] == 8'hA5) s = i;
        end
        x = 8'h00;
        for (int k = 0; k < N; k++) begin
            exp_wr.push_back({4'(k), stim_q[s + 1 + k]});
            x = x ^ stim_q[s + 1 + k];
        end
        m_done = (stim_q[s + N + 1] == x);
        m_code = m_done ? 2'b00 : 2'b01;
    endtask

    task automatic run_stream(input string tag, input int maxgap);
        int bw;
        int bd;
        int be;
        int bad;
        bw = got_q.size();
        bd = done_cnt;
        be = err_cnt;
        foreach (stim_q[i]) begin
            repeat ($urandom_range(maxgap, 0)) drive(1'b0, 8'h00);
            drive(1'b1, stim_q[i]);
        end
        repeat (3) drive(1'b0, 8'h00);
        check({tag, "_nwr"}, 32'(got_q.size() - bw), 32'(exp_wr.size()));
        bad = 0;
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (bw + i >= got_q.size()) bad++;
            else if (got_q[bw + i] !== exp_wr[i]) bad++;
        end
        check({tag, "_wrdata_bad"}, 32'(bad), 32'd0);
        act_done = done_cnt - bd;
        act_err  = err_cnt - be;
    endtask

    initial begin
        int         seen;
        int         bd;
        int         be;
        int         bw;
        logic [1:0] tcode;
        logic       tbusy;
        logic [7:0] r;

        tbl[0] = '{0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 2'b00};
        tbl[1] = '{0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 1'b0, 1'b1, 2'b01};
        tbl[2] = '{2, 8'h33, 8'h44, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 2'b00};
        tbl[3] = '{0, 8'h00, 8'h00, 8'hA0, 8'h01, 8'h00, 1'b1, 1'b0, 2'b00};
        tbl[4] = '{0, 8'h00, 8'h00, 8'h5A, 8'h11, 8'h80, 1'b0, 1'b1, 2'b01};
        tbl[5] = '{1, 8'h33, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00};

        rsnt  = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        #2 rsnt = 1'b0;
        #1;
        check("reset_outputs", 32'({mem_we, mem_addr, mem_data, busy, done, ferr, code}), 32'd0);
        #20;
        @(negedge clk);
        rsnt = 1'b1;
        repeat (2) drive(1'b0, 8'h00);

        for (int t = 0; t < 6; t++) begin
            build_frame(tbl[t].njunk, tbl[t].j0, tbl[t].j1, tbl[t].base, tbl[t].step, tbl[t].delta);
            model_run();
            run_stream($sformatf("tbl%0d", t), (t == 2) ? 2 : 0);
            check($sformatf("tbl%0d_done", t), 32'(act_done), 32'(tbl[t].exp_done));
            check($sformatf("tbl%0d_err", t), 32'(act_err), 32'(tbl[t].exp_err));
            check($sformatf("tbl%0d_code", t), 32'(code), 32'(tbl[t].exp_code));
        end

        // Write latency, hold behaviour, then inter-byte timeout after five pixels.
        bw = got_q.size();
        bd = done_cnt;
        be = err_cnt;
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h3C);
        drive(1'b0, 8'h00);
        check("lat_write", 32'({mem_we, mem_addr, mem_data, busy}), 32'({1'b1, 4'h0, 8'h3C, 1'b1}));
        drive(1'b0, 8'h00);
        check("hold_idle", 32'({mem_we, mem_addr, mem_data}), 32'({1'b0, 4'h0, 8'h3C}));
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(8'h40 + i));
        seen  = 0;
        tcode = 2'b00;
        tbusy = 1'b1;
        for (int j = 1; j <= 200; j++) begin
            drive(1'b0, 8'h00);
            if (ferr) begin
                seen  = j;
                tcode = code;
                tbusy = busy;
                break;
            end
        end
        check("to_cycles", 32'(seen), 32'd101);
        check("to_code_busy", 32'({tcode, tbusy}), 32'({2'b10, 1'b0}));
        repeat (3) drive(1'b0, 8'h00);
        check("to_nwr", 32'(got_q.size() - bw), 32'd5);
        check("to_pulses", 32'({done_cnt - bd, err_cnt - be}), 32'({32'd0, 32'd1}));

        build_frame(0, 8'h00, 8'h00, 8'h10, 8'h07, 8'h00);
        model_run();
        run_stream("after_to", 1);
        check("after_to_done", 32'(act_done), 32'd1);
        check("after_to_code", 32'(code), 32'd0);

        // A strobe landing on the expiry cycle keeps the frame alive.
        bw = got_q.size();
        bd = done_cnt;
        be = err_cnt;
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h00);
        repeat (99) drive(1'b0, 8'h00);
        for (int i = 1; i < N; i++) drive(1'b1, 8'(i));
        drive(1'b1, 8'h00);
        repeat (3) drive(1'b0, 8'h00);
        check("edge_nwr", 32'(got_q.size() - bw), 32'd16);
        check("edge_pulses", 32'({done_cnt - bd, err_cnt - be}), 32'({32'd1, 32'd0}));

        // Reset after pixel 7 clears outputs at once and issues no pulse.
        bd = done_cnt;
        be = err_cnt;
        drive(1'b1, 8'hA5);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h70 + i));
        drive(1'b0, 8'h00);
        check("pre_rst_write", 32'({mem_we, mem_addr, mem_data}), 32'({1'b1, 4'h7, 8'h77}));
        rsnt = 1'b0;
        #1;
        check("midrst_outputs", 32'({mem_we, mem_addr, mem_data, busy, done, ferr, code}), 32'd0);
        @(negedge clk);
        rsnt = 1'b1;
        repeat (3) drive(1'b0, 8'h00);
        check("midrst_pulses", 32'({done_cnt - bd, err_cnt - be}), 32'd0);
        build_frame(0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00);
        model_run();
        run_stream("post_rst", 0);
        check("post_rst_done", 32'(act_done), 32'd1);

        // Random frames with junk prefixes, gaps and occasional bad checksums.
        for (int f = 0; f < 20; f++) begin
            stim_q.delete();
            for (int k = 0; k < $urandom_range(2, 0); k++) begin
                r = 8'($urandom);
                if (r == 8'hA5) r = 8'h00;
                stim_q.push_back(r);
            end
            stim_q.push_back(8'hA5);
            r = 8'h00;
            for (int k = 0; k < N; k++) begin
                stim_q.push_back(8'($urandom));
                r = r ^ stim_q[stim_q.size() - 1];
            end
            if ($urandom_range(3, 0) == 0) r = r ^ 8'(1 << $urandom_range(7, 0));
            stim_q.push_back(r);
            model_run();
            run_stream($sformatf("rnd%0d", f), 3);
            check($sformatf("rnd%0d_done", f), 32'(act_done), 32'(m_done));
            check($sformatf("rnd%0d_err", f), 32'(act_err), 32'(!m_done));
            check($sformatf("rnd%0d_code", f), 32'(code), 32'(m_code));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
